// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the 6-stage core: merges ID/EX/memory stall requests,
// sequences memory waits with timeout and deferred flush. Optional counters: STALL_PERF_EN.
module pipe_stall_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             flush_req,
  output logic [5:0]       stall,
  output logic             flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            flush_pending_q, flush_pending_d;

  logic            mem_stall;
  logic            flush_int;
  logic            timeout_int;
  logic [5:0]      stall_int;

  // Handshake: a memory access is complete in any cycle where mem_ack=1; no ready/valid
  // back-pressure beyond that. A memory stall this cycle turns flush_req into a deferred flush.
  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    flush_pending_d = flush_pending_q;
    mem_stall       = 1'b0;
    flush_int       = 1'b0;
    timeout_int     = 1'b0;
    stall_int       = 6'b000000;

    case (state_q)
      IDLE: begin
        if (flush_pending_q) begin
          // Deferred flush dominates a new mem_req; that request is flushed away.
          flush_int       = 1'b1;
          flush_pending_d = 1'b0;
        end else if (mem_req && !mem_ack) begin
          mem_stall  = 1'b1;
          state_d    = WAIT;
          wait_cnt_d = TO_W'(1);
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q >= TO_W'(TIMEOUT)) begin
          timeout_int     = 1'b1;
          flush_int       = 1'b1;
          flush_pending_d = 1'b0;
          state_d         = IDLE;
          wait_cnt_d      = '0;
        end else begin
          mem_stall  = 1'b1;
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase

    if (mem_stall) begin
      stall_int = 6'b011111;
      if (flush_req) flush_pending_d = 1'b1;
    end else if (flush_req) begin
      flush_int       = 1'b1;
      flush_pending_d = 1'b0;
    end else if (!flush_int) begin
      if (stallreq_ex)      stall_int = 6'b001111;
      else if (stallreq_id) stall_int = 6'b000111;
    end
  end

  assign stall       = rst_n ? stall_int   : 6'b000000;
  assign flush       = rst_n ? flush_int   : 1'b0;
  assign mem_timeout = rst_n ? timeout_int : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      wait_cnt_q      <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      flush_pending_q <= flush_pending_d;
    end
  end

`ifdef STALL_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

  // Both counters saturate at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if ((stall != 6'b000000) && (stall_cycles_q != '1))
        stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      if (flush && (flush_count_q != '1))
        flush_count_q <= flush_count_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: expected {stall,flush,mem_timeout} queued per step.
module tb_pipe_stall_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;

  logic             clk;
  logic             rst_n;
  logic             stallreq_id, stallreq_ex, mem_req, mem_ack, flush_req;
  logic [5:0]       stall;
  logic             flush, mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  logic [7:0] exp_q[$];
  string      tag_q[$];
  int         vectors;
  int         miscompares;

  pipe_stall_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .mem_req(mem_req), .mem_ack(mem_ack), .flush_req(flush_req),
    .stall(stall), .flush(flush), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_out();
    logic [7:0] e;
    logic [7:0] obs;
    string      t;
    e   = exp_q.pop_front();
    t   = tag_q.pop_front();
    obs = {stall, flush, mem_timeout};
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: stall/flush/to got %b/%b/%b want %b/%b/%b",
             t, obs[7:2], obs[1], obs[0], e[7:2], e[1], e[0]);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, check at the falling edge.
  task automatic step(input logic id, input logic ex, input logic req, input logic ack,
                      input logic fl, input logic [5:0] es, input logic ef, input logic et,
                      input string tag);
    stallreq_id = id;
    stallreq_ex = ex;
    mem_req     = req;
    mem_ack     = ack;
    flush_req   = fl;
    exp_q.push_back({es, ef, et});
    tag_q.push_back(tag);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input logic [CNT_W-1:0] got, input logic [CNT_W-1:0] want,
                           input string tag);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  initial begin
    logic [5:0]       es;
    logic [CNT_W-1:0] exp_sc, exp_fc;
    logic             rid, rex;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;

    // Reset with every request high: outputs forced quiet.
    step(1, 1, 1, 0, 1, 6'b000000, 0, 0, "reset_c0");
    step(1, 1, 1, 0, 1, 6'b000000, 0, 0, "reset_c1");
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 6'b000000, 0, 0, "post_reset_idle");

    // Priority ladder.
    step(1, 0, 0, 0, 0, 6'b000111, 0, 0, "prio_id");
    step(1, 1, 0, 0, 0, 6'b001111, 0, 0, "prio_ex");
    step(1, 1, 1, 0, 0, 6'b011111, 0, 0, "prio_mem");
    step(0, 0, 0, 1, 0, 6'b000000, 0, 0, "prio_mem_ack");
    step(0, 1, 0, 0, 1, 6'b000000, 1, 0, "flush_over_ex");
    step(1, 0, 1, 1, 0, 6'b000111, 0, 0, "req_ack_same_cycle");

    // Random ID/EX requests with no memory traffic.
    for (int i = 0; i < 8; i++) begin
      rid = 1'($urandom_range(0, 1));
      rex = 1'($urandom_range(0, 1));
      es  = rex ? 6'b001111 : (rid ? 6'b000111 : 6'b000000);
      step(rid, rex, 0, 0, 0, es, 0, 0, "rand_id_ex");
    end

    // Clear counters before the counted scenarios.
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0, 6'b000000, 0, 0, "reset_mid");
    rst_n = 1'b1;

    // Memory wait, ack on cycle 3.
    step(0, 0, 1, 0, 0, 6'b011111, 0, 0, "wait_c0");
    step(0, 0, 1, 0, 0, 6'b011111, 0, 0, "wait_c1");
    step(0, 0, 1, 0, 0, 6'b011111, 0, 0, "wait_c2");
    step(0, 0, 1, 1, 0, 6'b000000, 0, 0, "wait_ack_c3");
    step(0, 0, 0, 0, 0, 6'b000000, 0, 0, "wait_idle_c4");

    // Deferred flush: two requests merge, issued once after ack, dropping a new mem_req.
    step(0, 0, 1, 0, 0, 6'b011111, 0, 0, "defer_c0");
    step(0, 0, 1, 0, 1, 6'b011111, 0, 0, "defer_c1");
    step(0, 0, 1, 0, 1, 6'b011111, 0, 0, "defer_c2");
    step(0, 0, 1, 0, 0, 6'b011111, 0, 0, "defer_c3");
    step(0, 0, 1, 1, 0, 6'b000000, 0, 0, "defer_ack_c4");
    step(0, 0, 1, 0, 0, 6'b000000, 1, 0, "defer_flush_c5");
    step(0, 0, 0, 0, 0, 6'b000000, 0, 0, "defer_after_c6");

`ifdef STALL_PERF_EN
    exp_sc = CNT_W'(7);
    exp_fc = CNT_W'(1);
`else
    exp_sc = '0;
    exp_fc = '0;
`endif
    check_cnt(stall_cycles, exp_sc, "stall_cycles");
    check_cnt(flush_count, exp_fc, "flush_count");

    // Timeout, with a flush request mid-wait that the timeout flush must consume.
    step(0, 0, 1, 0, 0, 6'b011111, 0, 0, "to_c0");
    for (int c = 1; c < TIMEOUT; c++)
      step(0, 0, 1, 0, (c == 5), 6'b011111, 0, 0, "to_stall");
    step(0, 0, 1, 0, 0, 6'b000000, 1, 1, "to_c16");
    step(0, 0, 0, 0, 0, 6'b000000, 0, 0, "to_c17");

    // Ack arriving on the would-be timeout cycle wins.
    step(0, 0, 1, 0, 0, 6'b011111, 0, 0, "ackwin_c0");
    for (int c = 1; c < TIMEOUT; c++)
      step(0, 0, 1, 0, 0, 6'b011111, 0, 0, "ackwin_stall");
    step(0, 0, 1, 1, 0, 6'b000000, 0, 0, "ackwin_c16");
    step(0, 0, 0, 0, 0, 6'b000000, 0, 0, "ackwin_after");

    // Reset mid-wait abandons the access without a timeout or flush.
    step(0, 0, 1, 0, 0, 6'b011111, 0, 0, "rstwait_c0");
    step(0, 0, 1, 0, 1, 6'b011111, 0, 0, "rstwait_c1");
    rst_n = 1'b0;
    step(0, 0, 1, 0, 0, 6'b000000, 0, 0, "rstwait_rst");
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 6'b000000, 0, 0, "rstwait_idle");
    step(1, 0, 0, 0, 0, 6'b000111, 0, 0, "rstwait_id");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
